// File: rtl/vproc_pkg.sv
// rtl/vproc_pkg.sv - shared multiplier operation encoding and operand helper
package vproc_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_e;

  // Magnitude of an operand; 0x80000000 maps to itself, read as unsigned 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/vproc_mul_iter_step.sv
// rtl/vproc_mul_iter_step.sv - one radix-2^BITS_PER_CYCLE partial-product accumulate
module vproc_mul_iter_step #(
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic [63:0]               acc_i,
  input  logic [31:0]               mcand_i,
  input  logic [BITS_PER_CYCLE-1:0] digit_i,
  input  logic [5:0]                shift_i,
  output logic [63:0]               acc_o
);

  logic [63:0] pp;

  assign pp    = {32'd0, mcand_i} * {{(64-BITS_PER_CYCLE){1'b0}}, digit_i};
  assign acc_o = acc_i + (pp << shift_i);

endmodule

// File: rtl/vproc_mul_iter.sv
// rtl/vproc_mul_iter.sv - iterative 32x32 multiplier (MUL/MULH/MULHSU/MULHU)
// Optional VPROC_MUL_EARLY_EXIT_EN: zero operand skips CALC and returns 0 next cycle.
module vproc_mul_iter
  import vproc_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic        clk_i,
  input  logic        async_rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [1:0]  op_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] res_o,
  output logic        busy_o
);

  localparam int unsigned N        = 32 / BITS_PER_CYCLE;
  localparam logic [5:0]  CNT_LAST = 6'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e      state_q, state_d;
  mul_op_e     op_q, op_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic        neg_q, neg_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;

  logic [63:0] acc_step;
  logic [5:0]  step_shift;

  assign step_shift = cnt_q * 6'(BITS_PER_CYCLE);

  vproc_mul_iter_step #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .acc_i  (acc_q),
    .mcand_i(mcand_q),
    .digit_i(mplier_q[BITS_PER_CYCLE-1:0]),
    .shift_i(step_shift),
    .acc_o  (acc_step)
  );

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      state_q  <= IDLE;
      op_q     <= MUL;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
    end
  end

  always_comb begin
    logic        sgn1;
    logic        sgn2;
    mul_op_e     op_in;
    logic [63:0] prod;

    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    op_in    = mul_op_e'(op_i);
    sgn1     = (op_in == MULH) || (op_in == MULHSU);
    sgn2     = (op_in == MULH);
    prod     = '0;

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          op_d     = op_in;
          mcand_d  = abs32(op1_i, sgn1);
          mplier_d = abs32(op2_i, sgn2);
          neg_d    = (sgn1 & op1_i[31]) ^ (sgn2 & op2_i[31]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
`ifdef VPROC_MUL_EARLY_EXIT_EN
          if ((op1_i == '0) || (op2_i == '0)) begin
            state_d = DONE;
            res_d   = '0;
          end
`endif
        end
      end
      CALC: begin
        acc_d    = acc_step;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == CNT_LAST) begin
          // Final step folds straight into the result register.
          prod    = neg_q ? (~acc_step + 64'd1) : acc_step;
          res_d   = (op_q == MUL) ? prod[31:0] : prod[63:32];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign res_o       = res_q;

endmodule

// File: doc/vproc_mul_iter.md
VPROC_MUL_ITER -- requirements
Module: vproc_mul_iter

Interface
REQ-001 SHALL have parameter BITS_PER_CYCLE, default 2, meaning multiplier bits retired per CALC cycle; legal values 1, 2, 4; N = 32/BITS_PER_CYCLE.
REQ-002 SHALL have port clk_i  input  1  clock; one clock, all state on its rising edge.
REQ-003 SHALL have port async_rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid_i  input  1  request valid.
REQ-005 SHALL have port in_ready_o  output  1  request accepted when high together with in_valid_i.
REQ-006 SHALL have port op_i  input  2  vproc_pkg::mul_op_e: MUL, MULH, MULHSU, MULHU.
REQ-007 SHALL have ports op1_i and op2_i  input  32 each  multiplicand and multiplier.
REQ-008 SHALL have port out_valid_o  output  1  result valid.
REQ-009 SHALL have port out_ready_i  input  1  consumer ready.
REQ-010 SHALL have port res_o  output  32  result.
REQ-011 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM IDLE, CALC, DONE; in_ready_o = (state==IDLE); out_valid_o = (state==DONE).
REQ-013 Accept = in_valid_i & in_ready_o; at accept SHALL capture op_i, |op1|, |op2| and negate flag; IDLE->CALC, iteration counter cleared; later input changes ignored.
REQ-014 Signedness: op1 signed for MULH/MULHSU; op2 signed for MULH only; unsigned operands taken as-is; negate = XOR of signs of signed operands.
REQ-015 Each CALC cycle SHALL add (|op1| x next BITS_PER_CYCLE bits of |op2|) shifted to bit position into a 64-bit accumulator, LSB first.
REQ-016 After exactly N CALC cycles SHALL go CALC->DONE, applying two's-complement negation of the 64-bit product if negate is set.
REQ-017 res_o SHALL be product[31:0] for MUL, product[63:32] for MULH/MULHSU/MULHU; registered, stable throughout DONE.
REQ-018 out_valid_o SHALL rise in the (N+1)th cycle after the accept cycle; DONE->IDLE on out_valid_o & out_ready_i.
REQ-019 Backpressure: DONE held indefinitely while out_ready_i low; res_o unchanged; no new request accepted.
REQ-020 in_valid_i in the same cycle as the DONE->IDLE handshake SHALL NOT be accepted; accepted the following cycle (throughput one result per N+2 cycles).
REQ-021 All 32-bit products SHALL be exact modulo 2^64; no overflow special cases (0x80000000 handled as unsigned 2^31 magnitude).

Reset
REQ-022 Asserting async_rst_ni low SHALL immediately force IDLE: in_ready_o=1, out_valid_o=0, busy_o=0, res_o=0, accumulator and counter 0.
REQ-023 Reset mid-CALC or mid-DONE SHALL discard the operation with no output; first accept after release SHALL behave normally.

Configuration
REQ-024 Macro VPROC_MUL_EARLY_EXIT_EN defined: if captured op1 or op2 is zero, SHALL go IDLE->DONE directly, out_valid_o in 1st cycle after accept, res_o=0.
REQ-025 Macro undefined: zero operands take the full N+1-cycle latency with identical result.

Structure
REQ-026 mul_op_e (2-bit: MUL=0, MULH=1, MULHSU=2, MULHU=3) SHALL live in vproc_pkg; FSM state enum local to the module.
REQ-027 Partial-product/accumulate step SHALL be sub-module vproc_mul_iter_step (combinational, BITS_PER_CYCLE parameter).

Verification
REQ-028 MUL 7 x 6, BITS_PER_CYCLE=2 -> res_o=0x0000002A, out_valid_o rises 17 cycles after accept.
REQ-029 MULH 0x80000000 x 0x80000000 -> 0x40000000; MUL same operands -> 0x00000000.
REQ-030 MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU same -> 0xFFFFFFFE.
REQ-031 out_ready_i low 5 cycles in DONE, in_valid_i high -> res_o stable, in_ready_o=0, next request accepted the cycle after handshake.
REQ-032 async_rst_ni pulsed at CALC cycle 8 -> outputs at reset values, no out_valid_o; following MUL 3 x 5 -> 0x0000000F.
REQ-033 MUL 0x1234 x 0 -> res_o=0; out_valid_o 1 cycle after accept with VPROC_MUL_EARLY_EXIT_EN, 17 cycles without.
